// File: rtl/sg_slope_discriminator_if.sv
// Sample stream carrying CIC output words into the slope discriminator.
//   tdata  : CIC output word, sample sits at a fixed bit offset inside it
//   tvalid : sample strobe; there is no tready, every strobed word is accepted
interface sg_slope_discriminator_if #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32
);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/sg_slope_discriminator.sv
// Savitzky-Golay first-derivative filter followed by a Schmitt-trigger slope
// discriminator with warm-up gating, post-transition hold-off and
// peak/valley pulses.
//   clk, rst        : clock and synchronous active-high reset
//   S_AXIS_IN       : sample stream (tdata/tvalid), always accepted
//   lower_thr       : gradient <= lower_thr drives the state to 1
//   upper_thr       : gradient >  upper_thr drives the state to 0
//   holdoff_cycles  : clocks a new transition stays blocked after a change
//   gradient_out    : unnormalised SG gradient, gradient_valid strobes it
//   diff_state_out  : 1 = negative/flat slope
//   peak_pulse      : one clock on a 0->1 state change
//   valley_pulse    : one clock on a 1->0 state change
module sg_slope_discriminator #(
  parameter int unsigned ADC_WIDTH        = 16,
  parameter int unsigned START_BIT        = 5,
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned HALF_WIN         = 2,
  parameter int unsigned ACC_WIDTH        = 24,
  parameter int unsigned HOLDOFF_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  sg_slope_discriminator_if.slave     S_AXIS_IN,
  input  logic signed [ACC_WIDTH-1:0] lower_thr,
  input  logic signed [ACC_WIDTH-1:0] upper_thr,
  input  logic [HOLDOFF_WIDTH-1:0]    holdoff_cycles,
  output logic signed [ACC_WIDTH-1:0] gradient_out,
  output logic                        gradient_valid,
  output logic                        diff_state_out,
  output logic                        peak_pulse,
  output logic                        valley_pulse
);

  localparam int unsigned WIN       = 2 * HALF_WIN + 1;
  localparam int unsigned IDX_WIDTH = $clog2(WIN);
  localparam int unsigned CNT_WIDTH = $clog2(WIN + 1);
  localparam int unsigned MIN_ACC   = ADC_WIDTH + $clog2(HALF_WIN * (HALF_WIN + 1)) + 1;

  // Elaboration-time parameter sanity checks
  if (HALF_WIN < 1 || HALF_WIN > 4) begin : g_bad_half_win
    $error("HALF_WIN must be in 1..4");
  end
  if (ACC_WIDTH < MIN_ACC) begin : g_bad_acc_width
    $error("ACC_WIDTH too narrow for the gradient of this window");
  end
  if (START_BIT + ADC_WIDTH > AXIS_TDATA_WIDTH) begin : g_bad_slice
    $error("sample slice exceeds tdata");
  end

  typedef enum logic {
    ST_RISING  = 1'b0,
    ST_FALLING = 1'b1
  } slope_e;

  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic [ADC_WIDTH-1:0]        raw;
  logic signed [ACC_WIDTH-1:0] sample;
  logic signed [ACC_WIDTH-1:0] taps [WIN];
  logic [CNT_WIDTH-1:0]        warm_cnt;
  logic                        acc_q;
  logic signed [ACC_WIDTH-1:0] grad_sum;

  slope_e                      state_q, state_d, target;
  logic [HOLDOFF_WIDTH-1:0]    hold_q, hold_d;
  logic                        peak_d, valley_d;

  assign tdata  = S_AXIS_IN.tdata;
  assign tvalid = S_AXIS_IN.tvalid;

  // Sign-extend the embedded sample before any arithmetic
  assign raw    = tdata[START_BIT +: ADC_WIDTH];
  assign sample = {{(ACC_WIDTH - ADC_WIDTH){raw[ADC_WIDTH-1]}}, raw};

  // Tap delay line, warm-up counter and accepted-sample flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WIN); i++) taps[IDX_WIDTH'(i)] <= '0;
      warm_cnt <= '0;
      acc_q    <= 1'b0;
    end else begin
      acc_q <= tvalid;
      if (tvalid) begin
        taps[0] <= sample;
        for (int i = 1; i < int'(WIN); i++) taps[IDX_WIDTH'(i)] <= taps[IDX_WIDTH'(i - 1)];
        if (warm_cnt != CNT_WIDTH'(WIN)) warm_cnt <= warm_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Antisymmetric SG kernel: sum k*(newer - older) around the centre tap
  always_comb begin
    grad_sum = '0;
    for (int k = 1; k <= int'(HALF_WIN); k++) begin
      grad_sum = grad_sum + ACC_WIDTH'(k) *
                 (taps[IDX_WIDTH'(int'(HALF_WIN) - k)] - taps[IDX_WIDTH'(int'(HALF_WIN) + k)]);
    end
  end

  // Gradient register; the strobe is withheld until the window is full
  always_ff @(posedge clk) begin
    if (rst) begin
      gradient_out   <= '0;
      gradient_valid <= 1'b0;
    end else begin
      gradient_valid <= acc_q && (warm_cnt == CNT_WIDTH'(WIN));
      if (acc_q) gradient_out <= grad_sum;
    end
  end

  // Discriminator state, hold-off counter and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RISING;
      hold_q       <= '0;
      peak_pulse   <= 1'b0;
      valley_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      peak_pulse   <= peak_d;
      valley_pulse <= valley_d;
    end
  end

  // Schmitt decision; the lower threshold wins when the thresholds overlap
  always_comb begin
    state_d  = state_q;
    hold_d   = (hold_q != '0) ? hold_q - HOLDOFF_WIDTH'(1) : '0;
    peak_d   = 1'b0;
    valley_d = 1'b0;
    target   = state_q;
    if (gradient_out <= lower_thr)      target = ST_FALLING;
    else if (gradient_out > upper_thr)  target = ST_RISING;
    if (gradient_valid && (hold_q == '0) && (target != state_q)) begin
      state_d  = target;
      hold_d   = holdoff_cycles;
      peak_d   = (target == ST_FALLING);
      valley_d = (target == ST_RISING);
    end
  end

  assign diff_state_out = (state_q == ST_FALLING);

endmodule

// File: tb/tb_sg_slope_discriminator.sv
// Directed bench for sg_slope_discriminator: a vector table for the M=2
// ramp and hysteresis sequences, plus hand-written sequences for warm-up,
// reset mid-stream, tvalid gaps, hold-off and an M=4 full-scale window.
module tb_sg_slope_discriminator;

  logic               clk;
  logic               rst;
  logic signed [23:0] lower_thr, upper_thr;
  logic [15:0]        holdoff;

  logic signed [23:0] grad, grad4;
  logic               gv, st, pk, vl;
  logic               gv4, st4, pk4, vl4;

  int n_tests = 0;
  int n_fail  = 0;

  sg_slope_discriminator_if #(.AXIS_TDATA_WIDTH(32)) ax  ();
  sg_slope_discriminator_if #(.AXIS_TDATA_WIDTH(32)) ax4 ();

  sg_slope_discriminator #(
    .ADC_WIDTH(16), .START_BIT(5), .AXIS_TDATA_WIDTH(32),
    .HALF_WIN(2), .ACC_WIDTH(24), .HOLDOFF_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .S_AXIS_IN(ax.slave),
    .lower_thr(lower_thr), .upper_thr(upper_thr), .holdoff_cycles(holdoff),
    .gradient_out(grad), .gradient_valid(gv), .diff_state_out(st),
    .peak_pulse(pk), .valley_pulse(vl)
  );

  sg_slope_discriminator #(
    .ADC_WIDTH(16), .START_BIT(5), .AXIS_TDATA_WIDTH(32),
    .HALF_WIN(4), .ACC_WIDTH(24), .HOLDOFF_WIDTH(16)
  ) dut4 (
    .clk(clk), .rst(rst), .S_AXIS_IN(ax4.slave),
    .lower_thr(lower_thr), .upper_thr(upper_thr), .holdoff_cycles(holdoff),
    .gradient_out(grad4), .gradient_valid(gv4), .diff_state_out(st4),
    .peak_pulse(pk4), .valley_pulse(vl4)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  typedef struct {
    logic               r;
    logic               v;
    int                 s;
    logic signed [23:0] g;
    logic               gv;
    logic               st;
    logic               pk;
    logic               vl;
  } vec_t;

  vec_t vq[$];

  // Sample embedded at bit 5 with junk in the surrounding bits
  function automatic logic [31:0] mk(input int s);
    logic [15:0] s16;
    s16 = 16'(s);
    return {11'h2A5, s16, 5'h15};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input int s, input int g,
                     input logic egv, input logic est, input logic epk, input logic evl);
    vec_t e;
    e.r = r; e.v = v; e.s = s; e.g = 24'(g);
    e.gv = egv; e.st = est; e.pk = epk; e.vl = evl;
    vq.push_back(e);
  endtask

  // One clock on the M=2 stream; outputs are sampled 1 ns after the edge
  task automatic step(input logic r, input logic v, input int s);
    rst = r; ax.tvalid = v; ax.tdata = mk(s);
    @(posedge clk); #1;
  endtask

  task automatic step4(input logic r, input logic v, input int s);
    rst = r; ax4.tvalid = v; ax4.tdata = mk(s);
    @(posedge clk); #1;
  endtask

  int smp3 [15];
  int gexp [15];
  int sexp [15];
  int pat5 [4];
  int last_c, last_pk, n_trans;
  logic prev_st;

  initial begin
    rst = 1'b1; ax.tvalid = 1'b0; ax.tdata = '0; ax4.tvalid = 1'b0; ax4.tdata = '0;
    lower_thr = 24'sd0; upper_thr = 24'sd3; holdoff = 16'd0;
    repeat (2) @(posedge clk);
    #1;

    // Ramp up then down after five zeros; reset row also has tvalid high
    add(1,1,99,   0,0,0,0,0);
    for (int i = 0; i < 5; i++) add(0,1,0, 0,0,0,0,0);
    add(0,1,10,   0,1,0,0,0);
    add(0,1,20,  20,1,1,1,0);
    add(0,1,30,  50,1,0,0,1);
    add(0,1,40,  80,1,0,0,0);
    add(0,1,50, 100,1,0,0,0);
    add(0,1,60, 100,1,0,0,0);
    add(0,1,50, 100,1,0,0,0);
    add(0,1,40,  60,1,0,0,0);
    add(0,1,30,   0,1,0,0,0);
    add(0,1,20, -60,1,1,1,0);
    add(0,0,0, -100,1,1,0,0);
    add(0,0,0, -100,0,1,0,0);
    add(0,0,0, -100,0,1,0,0);
    // Reset from state 1 (no pulse), then gradients 2,-1,2,4 for hysteresis
    add(1,1,99,   0,0,0,0,0);
    add(0,1,0,    0,0,0,0,0);
    add(0,1,0,    0,0,0,0,0);
    add(0,1,2,    0,0,0,0,0);
    add(0,1,0,    4,0,0,0,0);
    add(0,1,1,    2,0,0,0,0);
    add(0,1,0,    2,1,0,0,0);
    add(0,1,3,   -1,1,0,0,0);
    add(0,1,1,    2,1,1,1,0);
    add(0,0,0,    4,1,1,0,0);
    add(0,0,0,    4,0,0,0,1);
    add(0,0,0,    4,0,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].v, vq[i].s);
      chk($sformatf("row%0d grad", i),   grad, vq[i].g);
      chk($sformatf("row%0d gvalid", i), gv,   vq[i].gv);
      chk($sformatf("row%0d state", i),  st,   vq[i].st);
      chk($sformatf("row%0d peak", i),   pk,   vq[i].pk);
      chk($sformatf("row%0d valley", i), vl,   vq[i].vl);
    end

    // Same ramp with tvalid every third clock; outputs hold between strobes
    smp3 = '{0,0,0,0,0,10,20,30,40,50,60,50,40,30,20};
    gexp = '{0,0,0,0,0,20,50,80,100,100,100,60,0,-60,-100};
    sexp = '{0,0,0,0,1,0,0,0,0,0,0,0,1,1,1};
    step(1,0,0);
    prev_st = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(0,1,smp3[i]);
      step(0,0,0);
      chk($sformatf("gap%0d grad", i), grad, gexp[i]);
      chk($sformatf("gap%0d gvalid", i), gv, (i >= 4) ? 1 : 0);
      step(0,0,0);
      chk($sformatf("gap%0d hold grad", i), grad, gexp[i]);
      chk($sformatf("gap%0d strobe low", i), gv, 0);
      chk($sformatf("gap%0d state", i), st, sexp[i]);
      chk($sformatf("gap%0d peak", i), pk, (sexp[i] == 1 && !prev_st) ? 1 : 0);
      chk($sformatf("gap%0d valley", i), vl, (sexp[i] == 0 && prev_st) ? 1 : 0);
      prev_st = sexp[i][0];
    end

    // Warm-up and reset mid-ramp
    step(1,0,0);
    for (int k = 1; k <= 4; k++) begin
      step(0,1,10*k);
      chk($sformatf("warm%0d gvalid", k), gv, 0);
    end
    step(0,1,50);
    chk("warm5 gvalid", gv, 0);
    step(0,0,0);
    chk("warm first gvalid", gv, 1);
    chk("warm first grad", grad, 100);
    step(0,0,0);
    chk("warm strobe one clk", gv, 0);
    chk("warm grad held", grad, 100);
    step(0,1,60);
    step(1,1,70);
    chk("midrst grad", grad, 0);
    chk("midrst gvalid", gv, 0);
    chk("midrst state", st, 0);
    chk("midrst peak", pk, 0);
    chk("midrst valley", vl, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0,1,10*k);
      chk($sformatf("rewarm%0d gvalid", k), gv, 0);
    end
    step(0,1,50);
    chk("rewarm5 gvalid", gv, 0);
    step(0,0,0);
    chk("rewarm first gvalid", gv, 1);
    chk("rewarm first grad", grad, 100);

    // Hold-off 20 with gradients alternating +5,-5,-5,+5
    pat5 = '{0,0,5,5};
    holdoff = 16'd20;
    step(1,0,0);
    last_c = -1; last_pk = -1; n_trans = 0;
    for (int c = 0; c < 120; c++) begin
      step(0,1,pat5[c % 4]);
      chk($sformatf("ho c%0d both pulses", c), pk & vl, 0);
      if (pk || vl) begin
        n_trans++;
        if (last_c >= 0) begin
          chk($sformatf("ho c%0d spacing>=21", c), (c - last_c >= 21) ? 1 : 0, 1);
          chk($sformatf("ho c%0d spacing<=24", c), (c - last_c <= 24) ? 1 : 0, 1);
          chk($sformatf("ho c%0d alternates", c), pk ? 1 : 0, (last_pk == 1) ? 0 : 1);
        end
        last_c = c;
        last_pk = pk ? 1 : 0;
      end
    end
    chk("ho transitions>=4", (n_trans >= 4) ? 1 : 0, 1);
    holdoff = 16'd0;

    // M=4 full-scale window, both polarities
    step4(1,0,0);
    for (int k = 0; k < 9; k++) begin
      step4(0,1,(k < 4) ? -32768 : (k == 4) ? 0 : 32767);
      chk($sformatf("m4 warm%0d gvalid", k), gv4, 0);
    end
    step4(0,1,32767);
    chk("m4 full-scale grad", grad4, 655350);
    chk("m4 gvalid", gv4, 1);
    for (int k = 1; k < 9; k++) step4(0,1,(k < 4) ? 32767 : (k == 4) ? 0 : -32768);
    step4(0,0,0);
    chk("m4 neg full-scale grad", grad4, -655350);
    chk("m4 neg gvalid", gv4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
